// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file constants and types for the writeback slice.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW = $clog2(NREG);
    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;
    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rf_writeback_if.sv
// rf_writeback_if: producer handshakes, decode reservation/read ports and register-file write port.
interface rf_writeback_if;
    import rv_pkg::*;
    logic alu_valid, alu_ready, mem_valid, mem_ready, rsv_valid, rsv_ready;
    reg_idx_t alu_rd, mem_rd, rsv_rd, rs1, rs2, rf_w;
    xlen_t alu_data, mem_data, rf_data;
    logic rs1_busy, rs2_busy, rf_we;
    logic [31:0] commit_cnt;
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rsv_valid, rsv_rd, rs1, rs2,
        input alu_ready, mem_ready, rsv_ready, rs1_busy, rs2_busy, rf_we, rf_w, rf_data, commit_cnt
    );
    modport slave (
        input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rsv_valid, rsv_rd, rs1, rs2,
        output alu_ready, mem_ready, rsv_ready, rs1_busy, rs2_busy, rf_we, rf_w, rf_data, commit_cnt
    );
endinterface

// File: rtl/rf_writeback_scoreboard.sv
// wb_scoreboard: busy bit per register, reservation grant, clear on writeback and two read ports.
module wb_scoreboard
    import rv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     rsv_valid,
    input  reg_idx_t rsv_rd,
    output logic     rsv_ready,
    input  logic     clr_en,
    input  reg_idx_t clr_rd,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output logic     rs1_busy,
    output logic     rs2_busy
);
    logic [NREG-1:0] busy, set_mask, clr_mask;
    always_comb begin
        rsv_ready = !busy[rsv_rd] || rsv_rd == REG_ZERO;
        set_mask = (rsv_valid && rsv_ready) ? NREG'(1) << rsv_rd : '0;
        clr_mask = clr_en ? NREG'(1) << clr_rd : '0;
        rs1_busy = busy[rs1];
        rs2_busy = busy[rs2];
    end
    // A fresh reservation outranks a stray result clearing a non-busy register.
    always_ff @(posedge clk or posedge reset)
        if (reset) busy <= '0;
        else busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates load/ALU results onto the registered register-file write port.
module rf_writeback
    import rv_pkg::*;
(
    input logic clk,
    input logic reset,
    rf_writeback_if.slave bus
);
    reg_idx_t rd;
    xlen_t data;
    logic wr;
    always_comb begin
        bus.mem_ready = 1'b1;
        bus.alu_ready = !bus.mem_valid;
        rd = bus.mem_valid ? bus.mem_rd : bus.alu_rd;
        data = bus.mem_valid ? bus.mem_data : bus.alu_data;
        wr = (bus.mem_valid || bus.alu_valid) && rd != REG_ZERO;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.rf_we <= 1'b0;
            bus.rf_w <= '0;
            bus.rf_data <= '0;
            bus.commit_cnt <= '0;
        end else begin
            bus.rf_we <= wr;
            if (wr) begin
                bus.rf_w <= rd;
                bus.rf_data <= data;
            end
            bus.commit_cnt <= bus.commit_cnt + 32'(wr);
        end
    wb_scoreboard sb (
        .clk(clk),
        .reset(reset),
        .rsv_valid(bus.rsv_valid),
        .rsv_rd(bus.rsv_rd),
        .rsv_ready(bus.rsv_ready),
        .clr_en(wr),
        .clr_rd(rd),
        .rs1(bus.rs1),
        .rs2(bus.rs2),
        .rs1_busy(bus.rs1_busy),
        .rs2_busy(bus.rs2_busy)
    );
endmodule
